// File: rtl/stepper_axis_ctrl.sv
// Purpose: single-axis stepper pulse generator behind a 4-register Avalon-MM slave.
// Latency: readdata is registered (1 cycle); first step rises DIR_SETUP cycles after a start is accepted.
// Backpressure: none; writes are always accepted, and move-related writes are dropped while busy.
//
// Ports:
//   clk, reset_n               - system clock, asynchronous active-low reset
//   address, write, writedata  - register write port (0 POSITION, 1 TARGET, 2 CTRL/STATUS, 3 PERIOD)
//   readdata                   - registered, zero-extended read of the addressed register
//   endstop                    - min-limit switch (asynchronous, synchronized internally)
//   step, dir                  - driver outputs; dir = 1 moves toward larger positions
//   position                   - current position counter
//   busy                       - high while a move is in progress
module stepper_axis_ctrl #(
  parameter int POS_W     = 12,
  parameter int PULSE_W   = 50,
  parameter int DIR_SETUP = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             endstop,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] position,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  localparam logic [31:0] PW         = 32'(PULSE_W);
  localparam logic [31:0] SETUP_LAST = 32'(DIR_SETUP - 1);
  localparam logic [31:0] HIGH_LAST  = 32'(PULSE_W - 1);
  localparam logic [15:0] PERIOD_RST = 16'd1000;

  state_t           state, state_nxt;
  logic [31:0]      cnt;
  logic [POS_W-1:0] target;
  logic [15:0]      period;
  logic             done, endstop_hit;
  logic             es_meta, es_sync;
  logic             es_pend, abort_pend;

  // register write decode
  logic wr_pos, wr_tgt, wr_ctrl, wr_per;
  logic start, abort, clear;
  assign wr_pos  = write && (address == 2'd0);
  assign wr_tgt  = write && (address == 2'd1);
  assign wr_ctrl = write && (address == 2'd2);
  assign wr_per  = write && (address == 2'd3);
  assign start   = wr_ctrl && writedata[0];
  assign abort   = wr_ctrl && writedata[1];
  assign clear   = wr_ctrl && writedata[2];

  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // Effective period is clamped so LOW always lasts at least one cycle.
  logic [31:0] period_ext, eff_period, low_last;
  assign period_ext = {16'd0, period};
  assign eff_period = (period_ext > PW) ? period_ext : (PW + 32'd1);
  assign low_last   = eff_period - PW - 32'd1;

  // The endstop only matters while moving toward it.
  logic es_stop;
  assign es_stop = es_sync && !dir;

  logic pos_zero, set_done, clr_done, set_hit, dir_load, dir_val;
  logic es_pend_set, abort_pend_set, pos_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= ((state_nxt != state) || (state == IDLE)) ? '0 : cnt + 32'd1;
      step  <= (state_nxt == HIGH);
    end
  end

  always_comb begin
    state_nxt      = state;
    pos_zero       = 1'b0;
    set_done       = 1'b0;
    clr_done       = 1'b0;
    set_hit        = 1'b0;
    dir_load       = 1'b0;
    dir_val        = dir;
    es_pend_set    = 1'b0;
    abort_pend_set = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (target == position) begin
            set_done = 1'b1;
          end else if (es_sync && (target < position)) begin
            // already sitting on the endstop and asked to go further down
            set_hit  = 1'b1;
            pos_zero = 1'b1;
          end else begin
            dir_load  = 1'b1;
            dir_val   = (target > position);
            clr_done  = 1'b1;
            state_nxt = SETUP;
          end
        end
      end
      SETUP: begin
        if (es_stop) begin
          set_hit   = 1'b1;
          pos_zero  = 1'b1;
          state_nxt = IDLE;
        end else if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == SETUP_LAST) begin
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        // stop requests during the pulse are held until it completes
        if (cnt == HIGH_LAST) begin
          if (es_stop || es_pend) begin
            set_hit   = 1'b1;
            pos_zero  = 1'b1;
            state_nxt = IDLE;
          end else if (abort || abort_pend) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = LOW;
          end
        end else begin
          es_pend_set    = es_stop;
          abort_pend_set = abort;
        end
      end
      LOW: begin
        if (es_stop) begin
          set_hit   = 1'b1;
          pos_zero  = 1'b1;
          state_nxt = IDLE;
        end else if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == low_last) begin
          if (position == target) begin
            set_done  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = HIGH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // position moves on every HIGH entry, in the direction latched at start
  assign pos_step = (state_nxt == HIGH) && (state != HIGH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      es_meta     <= 1'b0;
      es_sync     <= 1'b0;
      position    <= '0;
      target      <= '0;
      period      <= PERIOD_RST;
      dir         <= 1'b0;
      done        <= 1'b0;
      endstop_hit <= 1'b0;
      es_pend     <= 1'b0;
      abort_pend  <= 1'b0;
      readdata    <= '0;
    end else begin
      es_meta <= endstop;
      es_sync <= es_meta;

      if (pos_zero) begin
        position <= '0;
      end else if (pos_step) begin
        position <= dir ? position + 1'b1 : position - 1'b1;
      end else if (wr_pos && (state == IDLE)) begin
        position <= writedata[POS_W-1:0];
      end

      if (wr_tgt && (state == IDLE)) target <= writedata[POS_W-1:0];
      if (wr_per) period <= writedata[15:0];
      if (dir_load) dir <= dir_val;

      // clear is applied before whatever the same write's start does
      if (clear)    done <= 1'b0;
      if (set_done) done <= 1'b1;
      if (clr_done) done <= 1'b0;
      if (clear)    endstop_hit <= 1'b0;
      if (set_hit)  endstop_hit <= 1'b1;

      if (state_nxt != HIGH) begin
        es_pend    <= 1'b0;
        abort_pend <= 1'b0;
      end else begin
        if (es_pend_set)    es_pend    <= 1'b1;
        if (abort_pend_set) abort_pend <= 1'b1;
      end

      case (address)
        2'd0: readdata <= 32'(position);
        2'd1: readdata <= 32'(target);
        2'd2: readdata <= {28'd0, es_sync, done, endstop_hit, busy};
        2'd3: readdata <= {16'd0, period};
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// Purpose: scoreboard bench for stepper_axis_ctrl; expected pulses and reads are queued at issue time.
// Latency: monitor compares step rises against queued rise cycles and reads one cycle after issue.
// Backpressure: none; the monitor runs on every falling clock edge.
module tb_stepper_axis_ctrl;
  localparam int POS_W     = 12;
  localparam int PULSE_W   = 4;
  localparam int DIR_SETUP = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             write;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             endstop;
  logic             step;
  logic             dir;
  logic [POS_W-1:0] position;
  logic             busy;

  stepper_axis_ctrl #(.POS_W(POS_W), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .readdata(readdata), .endstop(endstop),
    .step(step), .dir(dir), .position(position), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int last_wr = 0;

  typedef struct { int rise; logic d; int pos; } pulse_t;
  typedef struct { int due; logic [31:0] exp; } rd_t;
  pulse_t pulse_q[$];
  rd_t    rd_q[$];
  string  rd_name_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: step pulses and read data
  logic prev_step = 1'b0;
  int   hcnt = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_step = 1'b0;
      hcnt = 0;
    end else begin
      if (step && !prev_step) begin
        pulse_t e;
        chk("pulse_expected", 32'(pulse_q.size() != 0), 32'd1);
        if (pulse_q.size() != 0) begin
          e = pulse_q.pop_front();
          chk("rise_cycle", cyc, e.rise);
          chk("dir_at_step", 32'(dir), 32'(e.d));
          chk("pos_at_step", 32'(position), e.pos);
        end
        hcnt = 1;
      end else if (step) begin
        hcnt++;
      end else if (prev_step) begin
        chk("pulse_width", hcnt, PULSE_W);
      end
      prev_step = step;
    end
    while (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
      rd_t   r;
      string n;
      r = rd_q.pop_front();
      n = rd_name_q.pop_front();
      chk(n, readdata, r.exp);
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; write = 1'b1; last_wr = cyc;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    rd_t r;
    @(posedge clk); #1;
    address = a;
    r.due = cyc + 1;
    r.exp = exp;
    rd_q.push_back(r);
    rd_name_q.push_back(name);
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // reference: pulse k rises 1 + DIR_SETUP + (k-1)*max(period, PULSE_W+1) cycles after the start write
  task automatic push_move(input int p0, input int t, input int per, input int npulses);
    int eff;
    pulse_t e;
    eff = (per > PULSE_W) ? per : PULSE_W + 1;
    for (int k = 1; k <= npulses; k++) begin
      e.rise = last_wr + 1 + DIR_SETUP + (k - 1) * eff;
      e.d    = (t > p0);
      e.pos  = (t > p0) ? p0 + k : p0 - k;
      pulse_q.push_back(e);
    end
  endtask

  task automatic move(input int p0, input int t, input int per, input string name);
    int n;
    n = (t > p0) ? t - p0 : p0 - t;
    wr(2'd3, per);
    wr(2'd0, p0);
    wr(2'd1, t);
    wr(2'd2, 32'h5);
    push_move(p0, t, per, n);
    wait_idle(name);
    chk({name, "_pulses_left"}, pulse_q.size(), 0);
    rd(2'd0, t, {name, "_pos"});
    rd(2'd1, t, {name, "_tgt"});
    rd(2'd2, {28'd0, endstop, 1'b1, 1'b0, 1'b0}, {name, "_status"});
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, t, per, delta, r, n;
    reset_n = 1'b0; address = 2'd0; write = 1'b0; writedata = '0; endstop = 1'b0;
    #1;
    chk("rst_step", 32'(step), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_position", 32'(position), 0);
    chk("rst_readdata", readdata, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, 0, "rst_rd_pos");
    rd(2'd1, 0, "rst_rd_tgt");
    rd(2'd2, 0, "rst_rd_status");
    rd(2'd3, 1000, "rst_rd_period");
    drain();

    // directed moves
    move(0, 3, 10, "up3");
    move(5, 2, 10, "down3");
    move(0, 3, 0, "period_clamp");
    move(7, 7, 10, "null_move");
    move(4093, 4095, 6, "top_edge");
    move(2, 0, 7, "bottom_edge");

    // endstop ignored while moving up
    endstop = 1'b1;
    repeat (3) @(posedge clk);
    move(10, 13, 6, "es_up");
    endstop = 1'b0;
    repeat (3) @(posedge clk);

    // start toward an already-active endstop: zero position, no step
    endstop = 1'b1;
    repeat (3) @(posedge clk);
    wr(2'd0, 7);
    wr(2'd1, 3);
    wr(2'd2, 32'h5);
    repeat (10) @(posedge clk);
    rd(2'd0, 0, "es_idle_pos");
    rd(2'd2, 32'b1010, "es_idle_status");
    drain();
    endstop = 1'b0;
    repeat (3) @(posedge clk);

    // endstop during the 2nd pulse of a downward move
    wr(2'd3, 10);
    wr(2'd0, 100);
    wr(2'd1, 90);
    wr(2'd2, 32'h5);
    push_move(100, 90, 10, 2);
    r = last_wr + 1 + DIR_SETUP + 10;
    while (cyc < r) begin @(posedge clk); #1; end
    endstop = 1'b1;
    wait_idle("es_move");
    chk("es_move_pulses_left", pulse_q.size(), 0);
    rd(2'd0, 0, "es_move_pos");
    rd(2'd2, 32'b1010, "es_move_status");
    rd(2'd1, 90, "es_move_tgt");
    drain();
    endstop = 1'b0;
    repeat (3) @(posedge clk);

    // abort during LOW after the first step; TARGET write while busy is dropped
    wr(2'd3, 10);
    wr(2'd0, 0);
    wr(2'd1, 5);
    wr(2'd2, 32'h5);
    push_move(0, 5, 10, 1);
    r = last_wr + 1 + DIR_SETUP;
    while (cyc < r) begin @(posedge clk); #1; end
    wr(2'd1, 9);
    while (cyc < r + 5) begin @(posedge clk); #1; end
    chk("abort_busy_before", 32'(busy), 1);
    wr(2'd2, 32'h2);
    chk("abort_busy_after", 32'(busy), 0);
    repeat (20) @(posedge clk);
    chk("abort_pulses_left", pulse_q.size(), 0);
    rd(2'd0, 1, "abort_pos");
    rd(2'd1, 5, "abort_tgt");
    rd(2'd2, 0, "abort_status");
    drain();

    // randomized moves
    for (int i = 0; i < 10; i++) begin
      p0    = int'($urandom_range(0, 4095));
      delta = int'($urandom_range(0, 6));
      per   = int'($urandom_range(0, 14));
      if ($urandom_range(0, 1) == 1) t = (p0 + delta > 4095) ? 4095 : p0 + delta;
      else                           t = (p0 < delta) ? 0 : p0 - delta;
      move(p0, t, per, "rand");
    end

    // reset during a HIGH pulse
    wr(2'd3, 10);
    wr(2'd0, 0);
    wr(2'd1, 3);
    wr(2'd2, 32'h5);
    push_move(0, 3, 10, 3);
    n = 0;
    while (step !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("rst_mid_step_seen", 32'(step), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_step", 32'(step), 0);
    chk("rst_mid_readdata", readdata, 0);
    chk("rst_mid_busy", 32'(busy), 0);
    pulse_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, 0, "rst_mid_pos");
    rd(2'd1, 0, "rst_mid_tgt");
    rd(2'd3, 1000, "rst_mid_period");
    rd(2'd2, 0, "rst_mid_status");
    drain();

    chk("reads_left", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
